// File: rtl/execute_pkg.sv
// execute_pkg: shared constants and helpers for the execute stage.
//   - opcode and funct encodings
//   - link register index
//   - D/E pipeline register layout
//   - destination register selection
package execute_pkg;

    localparam int DATA_W = 32;
    localparam int DM_AW  = 8;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_LUI   = 6'd3;
    localparam logic [5:0] OP_ANDI  = 6'd4;
    localparam logic [5:0] OP_ORI   = 6'd5;
    localparam logic [5:0] OP_XORI  = 6'd6;
    localparam logic [5:0] OP_LW    = 6'd16;
    localparam logic [5:0] OP_LH    = 6'd18;
    localparam logic [5:0] OP_LB    = 6'd20;
    localparam logic [5:0] OP_SW    = 6'd24;
    localparam logic [5:0] OP_SH    = 6'd26;
    localparam logic [5:0] OP_SB    = 6'd28;
    localparam logic [5:0] OP_BEQ   = 6'd32;
    localparam logic [5:0] OP_BNE   = 6'd33;
    localparam logic [5:0] OP_BLT   = 6'd34;
    localparam logic [5:0] OP_BLE   = 6'd35;
    localparam logic [5:0] OP_J     = 6'd40;
    localparam logic [5:0] OP_JAL   = 6'd41;
    localparam logic [5:0] OP_JR    = 6'd42;

    localparam logic [4:0] FN_ADD = 5'd0;
    localparam logic [4:0] FN_SUB = 5'd2;
    localparam logic [4:0] FN_AND = 5'd8;
    localparam logic [4:0] FN_OR  = 5'd9;
    localparam logic [4:0] FN_XOR = 5'd10;
    localparam logic [4:0] FN_NOR = 5'd11;
    localparam logic [4:0] FN_SLL = 5'd16;
    localparam logic [4:0] FN_SRL = 5'd17;
    localparam logic [4:0] FN_SRA = 5'd18;

    localparam logic [4:0] REG_LINK = 5'd31;

    // All-zero value is a NOP (op 0, funct 0, rd 0).
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [5:0]        op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [10:0]       aux;
        logic [DATA_W-1:0] imm;
        logic [25:0]       addr;
        logic [DATA_W-1:0] os;
        logic [DATA_W-1:0] ot;
    } de_reg_t;

    function automatic logic [4:0] dest_reg(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        case (op)
            OP_RTYPE:                                       d = rd;
            OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI,
            OP_LW, OP_LH, OP_LB:                            d = rt;
            OP_JAL:                                         d = REG_LINK;
            default:                                        d = 5'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-side inputs, write-back forwarding inputs and
// execute-side outputs of the execute stage.
//   master: decoder / write-back side (drives *_d, *_w; sees *_e)
//   slave : execute_stage
interface execute_stage_if;

    logic                               bubble_d;
    logic [execute_pkg::DATA_W-1:0]     pc_d;
    logic [5:0]                         op_d;
    logic [4:0]                         rs_d;
    logic [4:0]                         rt_d;
    logic [4:0]                         rd_d;
    logic [10:0]                        aux_d;
    logic [execute_pkg::DATA_W-1:0]     imm_dpl_d;
    logic [25:0]                        addr_d;
    logic [execute_pkg::DATA_W-1:0]     os_d;
    logic [execute_pkg::DATA_W-1:0]     ot_d;
    logic [4:0]                         wreg_w;
    logic [execute_pkg::DATA_W-1:0]     w_data_w;

    logic [execute_pkg::DATA_W-1:0]     pc_e;
    logic [5:0]                         op_e;
    logic [25:0]                        addr_e;
    logic [execute_pkg::DATA_W-1:0]     imm_dpl_e;
    logic [execute_pkg::DATA_W-1:0]     os_e;
    logic [execute_pkg::DATA_W-1:0]     ot_e;
    logic [4:0]                         wreg_e;
    logic [execute_pkg::DATA_W-1:0]     result_e;

    modport master (
        output bubble_d, pc_d, op_d, rs_d, rt_d, rd_d, aux_d, imm_dpl_d,
               addr_d, os_d, ot_d, wreg_w, w_data_w,
        input  pc_e, op_e, addr_e, imm_dpl_e, os_e, ot_e, wreg_e, result_e
    );

    modport slave (
        input  bubble_d, pc_d, op_d, rs_d, rt_d, rd_d, aux_d, imm_dpl_d,
               addr_d, os_d, ot_d, wreg_w, w_data_w,
        output pc_e, op_e, addr_e, imm_dpl_e, os_e, ot_e, wreg_e, result_e
    );

endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: word-organised data memory with per-byte write enables.
//   clk      : write clock
//   i_we     : one enable per byte lane (lane 0 = bits 7:0)
//   i_addr   : word address (shared by read and write)
//   i_wdata  : write data, already lane-replicated by the caller
//   o_rdata  : asynchronous read; returns pre-write contents during a write
//   o_dbg_*  : (DM_DEBUG_TAP_EN only) fixed words 133, 144, 225
// Contents are not reset.
module dmem_bytelane #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [DW/8-1:0] i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   o_rdata
`ifdef DM_DEBUG_TAP_EN
    ,
    output logic [DW-1:0]   o_dbg_w133,
    output logic [DW-1:0]   o_dbg_w144,
    output logic [DW-1:0]   o_dbg_w225
`endif
);

    localparam int NLANE = DW / 8;

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANE; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

`ifdef DM_DEBUG_TAP_EN
    assign o_dbg_w133 = r_mem[133];
    assign o_dbg_w144 = r_mem[144];
    assign o_dbg_w225 = r_mem[225];
`endif

endmodule

// File: rtl/execute_stage.sv
// execute_stage: D/E pipeline register, operand forwarding from write-back,
// 32-bit integer ALU and byte-laned data memory.
//   clk, rstd  : clock; synchronous active-low reset (clears D/E register only)
//   de_bus     : execute_stage_if.slave - decode inputs, write-back forward
//                inputs, execute outputs
//   dbg_w133/144/225 : present only when DM_DEBUG_TAP_EN is defined;
//                combinational views of memory words 133, 144, 225
module execute_stage
    import execute_pkg::*;
#(
    parameter int XLEN          = DATA_W,
    parameter int DM_DEPTH_LOG2 = DM_AW
) (
    input  logic            clk,
    input  logic            rstd,
    execute_stage_if.slave  de_bus
`ifdef DM_DEBUG_TAP_EN
    ,
    output logic [XLEN-1:0] dbg_w133,
    output logic [XLEN-1:0] dbg_w144,
    output logic [XLEN-1:0] dbg_w225
`endif
);

    de_reg_t r_de;

    logic [XLEN-1:0]          w_os;
    logic [XLEN-1:0]          w_ot;
    logic [XLEN-1:0]          w_ea;
    logic [XLEN-1:0]          w_imm_zx;
    logic [XLEN-1:0]          w_rdata;
    logic [XLEN-1:0]          w_wdata;
    logic [3:0]               w_we;
    logic [XLEN-1:0]          w_result;
    logic [4:0]               w_shamt;
    logic [4:0]               w_funct;
    logic [DM_DEPTH_LOG2-1:0] w_widx;
    logic                     w_unused;

    always_ff @(posedge clk) begin
        if (!rstd || de_bus.bubble_d) begin
            r_de <= '0;
        end else begin
            r_de <= '{pc:   de_bus.pc_d,
                      op:   de_bus.op_d,
                      rs:   de_bus.rs_d,
                      rt:   de_bus.rt_d,
                      rd:   de_bus.rd_d,
                      aux:  de_bus.aux_d,
                      imm:  de_bus.imm_dpl_d,
                      addr: de_bus.addr_d,
                      os:   de_bus.os_d,
                      ot:   de_bus.ot_d};
        end
    end

    // Register 0 is never a real destination, so it never forwards.
    assign w_os = (de_bus.wreg_w != 5'd0 && de_bus.wreg_w == r_de.rs) ? de_bus.w_data_w : r_de.os;
    assign w_ot = (de_bus.wreg_w != 5'd0 && de_bus.wreg_w == r_de.rt) ? de_bus.w_data_w : r_de.ot;

    assign w_shamt  = r_de.aux[10:6];
    assign w_funct  = r_de.aux[4:0];
    assign w_imm_zx = {16'b0, r_de.imm[15:0]};
    assign w_ea     = w_os + r_de.imm;
    assign w_widx   = w_ea[DM_DEPTH_LOG2+1:2];

    always_comb begin
        w_we    = 4'b0000;
        w_wdata = w_ot;
        case (r_de.op)
            OP_SW: w_we = 4'b1111;
            OP_SH: begin
                w_wdata = {2{w_ot[15:0]}};
                w_we    = w_ea[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                w_wdata = {4{w_ot[7:0]}};
                w_we    = 4'b0001 << w_ea[1:0];
            end
            default: ;
        endcase
        // The instruction in E during a reset edge is discarded, stores included.
        if (!rstd) begin
            w_we = 4'b0000;
        end
    end

    dmem_bytelane #(
        .AW (DM_DEPTH_LOG2),
        .DW (XLEN)
    ) u_dmem (
        .clk        (clk),
        .i_we       (w_we),
        .i_addr     (w_widx),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rdata)
`ifdef DM_DEBUG_TAP_EN
        ,
        .o_dbg_w133 (dbg_w133),
        .o_dbg_w144 (dbg_w144),
        .o_dbg_w225 (dbg_w225)
`endif
    );

    always_comb begin
        w_result = '0;
        case (r_de.op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  w_result = w_os + w_ot;
                    FN_SUB:  w_result = w_os - w_ot;
                    FN_AND:  w_result = w_os & w_ot;
                    FN_OR:   w_result = w_os | w_ot;
                    FN_XOR:  w_result = w_os ^ w_ot;
                    FN_NOR:  w_result = ~(w_os | w_ot);
                    FN_SLL:  w_result = w_ot << w_shamt;
                    FN_SRL:  w_result = w_ot >> w_shamt;
                    FN_SRA:  w_result = $signed(w_ot) >>> w_shamt;
                    default: w_result = '0;
                endcase
            end
            OP_ADDI: w_result = w_os + r_de.imm;
            OP_LUI:  w_result = r_de.imm << 16;
            OP_ANDI: w_result = w_os & w_imm_zx;
            OP_ORI:  w_result = w_os | w_imm_zx;
            OP_XORI: w_result = w_os ^ w_imm_zx;
            OP_LW:   w_result = w_rdata;
            OP_LH:   w_result = w_ea[1] ? {{16{w_rdata[31]}}, w_rdata[31:16]}
                                        : {{16{w_rdata[15]}}, w_rdata[15:0]};
            OP_LB: begin
                case (w_ea[1:0])
                    2'd0:    w_result = {{24{w_rdata[7]}},  w_rdata[7:0]};
                    2'd1:    w_result = {{24{w_rdata[15]}}, w_rdata[15:8]};
                    2'd2:    w_result = {{24{w_rdata[23]}}, w_rdata[23:16]};
                    default: w_result = {{24{w_rdata[31]}}, w_rdata[31:24]};
                endcase
            end
            OP_JAL:  w_result = r_de.pc + 32'd4;
            default: w_result = '0;
        endcase
    end

    assign de_bus.pc_e      = r_de.pc;
    assign de_bus.op_e      = r_de.op;
    assign de_bus.addr_e    = r_de.addr;
    assign de_bus.imm_dpl_e = r_de.imm;
    assign de_bus.os_e      = w_os;
    assign de_bus.ot_e      = w_ot;
    assign de_bus.wreg_e    = dest_reg(r_de.op, r_de.rt, r_de.rd);
    assign de_bus.result_e  = w_result;

    assign w_unused = ^{w_ea[XLEN-1:DM_DEPTH_LOG2+2], r_de.aux[5]};

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [10:0] aux;
        logic [31:0] imm, os, ot, res;
        logic [4:0]  wreg;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  wreg;
    } exp_t;

    logic clk = 1'b0;
    logic rstd;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];

    execute_stage_if bus();

`ifdef DM_DEBUG_TAP_EN
    logic [31:0] dbg_w133, dbg_w144, dbg_w225;
    execute_stage dut (.clk(clk), .rstd(rstd), .de_bus(bus),
                       .dbg_w133(dbg_w133), .dbg_w144(dbg_w144), .dbg_w225(dbg_w225));
`else
    execute_stage dut (.clk(clk), .rstd(rstd), .de_bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic logic [10:0] aux_f(input int shamt, input int funct);
        return {shamt[4:0], 1'b0, funct[4:0]};
    endfunction

    function automatic vec_t mk(input string tag, input int op, input int rs, input int rt,
                                input int rd, input logic [10:0] aux, input logic [31:0] imm,
                                input logic [31:0] os, input logic [31:0] ot,
                                input logic [31:0] res, input int wreg);
        vec_t v;
        v.tag = tag; v.op = op[5:0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.rd = rd[4:0];
        v.aux = aux; v.imm = imm; v.os = os; v.ot = ot; v.res = res; v.wreg = wreg[4:0];
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        bus.bubble_d  = 1'b0;
        bus.pc_d      = 32'h0;
        bus.op_d      = v.op;
        bus.rs_d      = v.rs;
        bus.rt_d      = v.rt;
        bus.rd_d      = v.rd;
        bus.aux_d     = v.aux;
        bus.imm_dpl_d = v.imm;
        bus.addr_d    = 26'h0;
        bus.os_d      = v.os;
        bus.ot_d      = v.ot;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstd = 1'b0;
        bus.wreg_w = 5'd0;
        bus.w_data_w = 32'h0;
        drive_vec(mk("rst", 1, 2, 9, 0, 11'h0, 32'hFFFFFFF9, 32'd5, 32'd0, 32'h0, 0));
        bus.pc_d = 32'h100;
        sb_q.push_back('{"reset", 32'h0, 5'd0});
        step();
        step();
        e = sb_q.pop_front();
        n_vec++;
        if (bus.result_e !== e.res || bus.wreg_e !== e.wreg) begin
            n_miss++;
            $display("FAIL %s: result_e=%h wreg_e=%0d, want %h / %0d", e.tag, bus.result_e, bus.wreg_e, e.res, e.wreg);
        end
        n_vec++;
        if (bus.op_e !== 6'd0 || bus.pc_e !== 32'h0 || bus.os_e !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_regs: op_e=%0d pc_e=%h os_e=%h, want 0 / 0 / 0", bus.op_e, bus.pc_e, bus.os_e);
        end
        rstd = 1'b1;
    endtask

    task automatic test_alu();
        vec_t v[$];
        exp_t e;
        v.push_back(mk("add",  0, 1, 2, 4, aux_f(0, 0),  0, 32'h12345678, 32'h0F0F0F0F, 32'h21436587, 4));
        v.push_back(mk("sub",  0, 1, 2, 4, aux_f(0, 2),  0, 32'h12345678, 32'h0F0F0F0F, 32'h03254769, 4));
        v.push_back(mk("and",  0, 1, 2, 5, aux_f(0, 8),  0, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 5));
        v.push_back(mk("or",   0, 1, 2, 6, aux_f(0, 9),  0, 32'h12345678, 32'h0F0F0F0F, 32'h1F3F5F7F, 6));
        v.push_back(mk("xor",  0, 1, 2, 7, aux_f(0, 10), 0, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977, 7));
        v.push_back(mk("nor",  0, 1, 2, 8, aux_f(0, 11), 0, 32'h12345678, 32'h0F0F0F0F, 32'hE0C0A080, 8));
        v.push_back(mk("sll",  0, 1, 2, 4, aux_f(4, 16), 0, 32'h0, 32'h0F0F0F0F, 32'hF0F0F0F0, 4));
        v.push_back(mk("srl",  0, 1, 2, 4, aux_f(4, 17), 0, 32'h0, 32'h8F0F0F0F, 32'h08F0F0F0, 4));
        v.push_back(mk("sra",  0, 1, 2, 4, aux_f(4, 18), 0, 32'h0, 32'h80000000, 32'hF8000000, 4));
        v.push_back(mk("sra+", 0, 1, 2, 4, aux_f(4, 18), 0, 32'h0, 32'h0F0F0F0F, 32'h00F0F0F0, 4));
        v.push_back(mk("fn1",  0, 1, 2, 4, aux_f(0, 1),  0, 32'h5, 32'h6, 32'h0, 4));
        v.push_back(mk("subw", 0, 1, 2, 4, aux_f(0, 2),  0, 32'h0, 32'h1, 32'hFFFFFFFF, 4));
        v.push_back(mk("addw", 0, 1, 2, 4, aux_f(0, 0),  0, 32'hFFFFFFFF, 32'h2, 32'h1, 4));
        v.push_back(mk("addi", 1, 1, 9, 0, 0, 32'hFFFFFFF9, 32'd5, 0, 32'hFFFFFFFE, 9));
        v.push_back(mk("lui",  3, 1, 9, 0, 0, 32'hFFFF8001, 32'd5, 0, 32'h80010000, 9));
        v.push_back(mk("andi", 4, 1, 9, 0, 0, 32'hFFFFFF0F, 32'h12345678, 0, 32'h00005608, 9));
        v.push_back(mk("ori",  5, 1, 9, 0, 0, 32'hFFFFFF0F, 32'h12345678, 0, 32'h1234FF7F, 9));
        v.push_back(mk("xori", 6, 1, 9, 0, 0, 32'hFFFFFF0F, 32'h12345678, 0, 32'h1234A977, 9));
        v.push_back(mk("beq",  32, 1, 9, 3, 0, 32'h0, 32'h0, 0, 32'h0, 0));
        v.push_back(mk("j",    40, 1, 9, 3, 0, 32'h0, 32'h0, 0, 32'h0, 0));
        v.push_back(mk("jr",   42, 1, 9, 3, 0, 32'h0, 32'h7, 0, 32'h0, 0));
        v.push_back(mk("op2",  2, 1, 9, 3, 0, 32'h1, 32'h7, 0, 32'h0, 0));
        v.push_back(mk("op63", 63, 1, 9, 3, 0, 32'h1, 32'h7, 0, 32'h0, 0));
        foreach (v[i]) begin
            drive_vec(v[i]);
            sb_q.push_back('{v[i].tag, v[i].res, v[i].wreg});
            step();
            e = sb_q.pop_front();
            n_vec++;
            if (bus.result_e !== e.res || bus.wreg_e !== e.wreg) begin
                n_miss++;
                $display("FAIL %s: result_e=%h wreg_e=%0d, want %h / %0d", e.tag, bus.result_e, bus.wreg_e, e.res, e.wreg);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [4:0]  fw_reg  [4] = '{5'd9, 5'd10, 5'd0, 5'd4};
        logic [31:0] fw_os   [4] = '{32'd100, 32'd5, 32'd5, 32'd5};
        logic [31:0] fw_ot   [4] = '{32'd7, 32'd100, 32'd7, 32'd7};
        exp_t e;
        drive_vec(mk("fwd", 0, 9, 10, 4, aux_f(0, 0), 0, 32'd5, 32'd7, 0, 4));
        step();
        for (int i = 0; i < 4; i++) begin
            bus.wreg_w   = fw_reg[i];
            bus.w_data_w = 32'd100;
            sb_q.push_back('{$sformatf("fwd%0d", i), fw_os[i] + fw_ot[i], 5'd4});
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (bus.os_e !== fw_os[i] || bus.ot_e !== fw_ot[i] || bus.result_e !== e.res) begin
                n_miss++;
                $display("FAIL %s: os_e=%0d ot_e=%0d result_e=%0d, want %0d / %0d / %0d",
                         e.tag, bus.os_e, bus.ot_e, bus.result_e, fw_os[i], fw_ot[i], e.res);
            end
        end
        bus.wreg_w   = 5'd0;
        bus.w_data_w = 32'h0;
    endtask

    task automatic test_mem();
        vec_t v[$];
        exp_t e;
        v.push_back(mk("sw532",  24, 1, 9, 0, 0, 32'd32, 32'd500, 32'h00000315, 32'h0, 0));
        v.push_back(mk("lw532",  16, 1, 9, 0, 0, 32'd0,  32'd532, 0, 32'h00000315, 9));
        v.push_back(mk("sb533",  28, 1, 9, 0, 0, 32'd33, 32'd500, 32'h12345680, 32'h0, 0));
        v.push_back(mk("lb533",  20, 1, 9, 0, 0, 32'd0,  32'd533, 0, 32'hFFFFFF80, 9));
        v.push_back(mk("lw532b", 16, 1, 9, 0, 0, 32'd0,  32'd532, 0, 32'h00008015, 9));
        v.push_back(mk("lh532",  18, 1, 9, 0, 0, 32'd0,  32'd532, 0, 32'hFFFF8015, 9));
        v.push_back(mk("sh534",  26, 1, 9, 0, 0, 32'd0,  32'd534, 32'h1111ABCD, 32'h0, 0));
        v.push_back(mk("lw532c", 16, 1, 9, 0, 0, 32'd0,  32'd532, 0, 32'hABCD8015, 9));
        v.push_back(mk("lh534",  18, 1, 9, 0, 0, 32'hFFFFFFFE, 32'd536, 0, 32'hFFFFABCD, 9));
        v.push_back(mk("lb535",  20, 1, 9, 0, 0, 32'd0,  32'd535, 0, 32'hFFFFFFAB, 9));
        v.push_back(mk("lb532",  20, 1, 9, 0, 0, 32'd0,  32'd532, 0, 32'h00000015, 9));
        v.push_back(mk("sw576",  24, 1, 9, 0, 0, 32'd0,  32'd576, 32'h7FFF0001, 32'h0, 0));
        v.push_back(mk("lh578",  18, 1, 9, 0, 0, 32'd2,  32'd576, 0, 32'h00007FFF, 9));
        v.push_back(mk("lw576",  16, 1, 9, 0, 0, 32'd0,  32'd576, 0, 32'h7FFF0001, 9));
        foreach (v[i]) begin
            drive_vec(v[i]);
            sb_q.push_back('{v[i].tag, v[i].res, v[i].wreg});
            step();
            e = sb_q.pop_front();
            n_vec++;
            if (bus.result_e !== e.res || bus.wreg_e !== e.wreg) begin
                n_miss++;
                $display("FAIL %s: result_e=%h wreg_e=%0d, want %h / %0d", e.tag, bus.result_e, bus.wreg_e, e.res, e.wreg);
            end
        end
`ifdef DM_DEBUG_TAP_EN
        n_vec++;
        if (dbg_w133 !== 32'hABCD8015 || dbg_w144 !== 32'h7FFF0001) begin
            n_miss++;
            $display("FAIL dbg_tap: w133=%h w144=%h, want abcd8015 / 7fff0001", dbg_w133, dbg_w144);
        end
`endif
    endtask

    task automatic test_reset_store();
        exp_t e;
        drive_vec(mk("swrst", 24, 1, 9, 0, 0, 32'd0, 32'd532, 32'hDEADBEEF, 0, 0));
        step();
        rstd = 1'b0;
        drive_vec(mk("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        rstd = 1'b1;
        drive_vec(mk("lwrst", 16, 1, 9, 0, 0, 32'd0, 32'd532, 0, 0, 9));
        sb_q.push_back('{"store_in_reset", 32'hABCD8015, 5'd9});
        step();
        e = sb_q.pop_front();
        n_vec++;
        if (bus.result_e !== e.res || bus.wreg_e !== e.wreg) begin
            n_miss++;
            $display("FAIL %s: result_e=%h wreg_e=%0d, want %h / %0d", e.tag, bus.result_e, bus.wreg_e, e.res, e.wreg);
        end
    endtask

    task automatic test_jal_bubble();
        exp_t e;
        drive_vec(mk("jal", 41, 1, 9, 3, 0, 32'h0, 32'h0, 0, 0, 0));
        bus.pc_d   = 32'h40;
        bus.addr_d = 26'h3ABCDEF;
        sb_q.push_back('{"jal", 32'h44, 5'd31});
        step();
        e = sb_q.pop_front();
        n_vec++;
        if (bus.result_e !== e.res || bus.wreg_e !== e.wreg || bus.pc_e !== 32'h40 || bus.addr_e !== 26'h3ABCDEF) begin
            n_miss++;
            $display("FAIL %s: result_e=%h wreg_e=%0d pc_e=%h addr_e=%h, want %h / %0d / 40 / 3abcdef",
                     e.tag, bus.result_e, bus.wreg_e, bus.pc_e, bus.addr_e, e.res, e.wreg);
        end
        bus.bubble_d = 1'b1;
        sb_q.push_back('{"bubble", 32'h0, 5'd0});
        step();
        e = sb_q.pop_front();
        n_vec++;
        if (bus.result_e !== e.res || bus.wreg_e !== e.wreg || bus.op_e !== 6'd0) begin
            n_miss++;
            $display("FAIL %s: result_e=%h wreg_e=%0d op_e=%0d, want %h / %0d / 0",
                     e.tag, bus.result_e, bus.wreg_e, bus.op_e, e.res, e.wreg);
        end
        bus.bubble_d = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_forwarding();
        test_mem();
        test_reset_store();
        test_jal_bubble();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Decode/execute pipeline register, execute-stage operand forwarding, 32-bit integer ALU and 256-word byte-laned data memory, all in one block.
- Sits between the decoder/register-file read and the execute/write-back register of the 3-stage educational pipeline.
- Branch/jump target selection is done by the PC unit; this block only supplies operands and results to it.

Parameters:
- DM_DEPTH_LOG2, 8, data memory word-address width (256 words).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstd  in  1  reset; synchronous, active-low.
- bubble_d  in  1  when 1, the D/E register loads a NOP instead of decode outputs.
- pc_d  in  32  byte PC of the decoded instruction.
- op_d  in  6  opcode.
- rs_d, rt_d, rd_d  in  5 each  register specifiers.
- aux_d  in  11  shamt = aux[10:6], funct = aux[4:0].
- imm_dpl_d  in  32  sign-extended immediate.
- addr_d  in  26  jump target field.
- os_d, ot_d  in  32 each  register-file read data.
- wreg_w  in  5  write-back destination register.
- w_data_w  in  32  write-back data.
- pc_e, op_e, addr_e, imm_dpl_e  out  registered copies of the decode inputs.
- os_e, ot_e  out  32 each  forwarded operands.
- wreg_e  out  5  destination register; 0 means no write.
- result_e  out  32  ALU or load result.

Behaviour:
- D/E register:
  - On every clk edge, captures all *_d inputs.
  - When rstd=0 or bubble_d=1, loads all zeros instead. op=0, funct=0, rd=0 is a NOP.
- Forwarding (combinational):
  - os_e = w_data_w when wreg_w!=0 and wreg_w==rs_e; otherwise the registered os.
  - ot_e is formed the same way, comparing against rt_e.
- ALU, op 0 (R-type), selected by funct:
  - 0 add, 2 sub, 8 and, 9 or, 10 xor, 11 nor.
  - 16 sll ot by shamt, 17 srl, 18 sra.
  - Other funct values: result 0.
- ALU, immediate ops (B = imm_dpl_e):
  - 1 addi: os+imm.
  - 3 lui: imm<<16.
  - 4 andi, 5 ori, 6 xori: logic op on os and imm[15:0] zero-extended.
- Arithmetic wraps modulo 2^32; no overflow trap.
- Memory address: byte address ea = os_e + imm_dpl_e. Word index = ea[9:2]; ea[1:0] selects the byte/half lane.
- Loads:
  - 16 lw: full word.
  - 18 lh: lane ea[1], sign-extended.
  - 20 lb: lane ea[1:0], sign-extended.
  - Memory read is asynchronous, so the result is valid in the same cycle.
- Stores (no register write):
  - 24 sw: all 4 lanes, data ot.
  - 26 sh: ot[15:0] replicated to both halves; lane enables 0011 or 1100 chosen by ea[1].
  - 28 sb: ot[7:0] replicated to all bytes; one-hot lane enable from ea[1:0].
  - Write occurs on the clk edge.
  - Same-cycle read of a word being written returns the old data.
- Jumps:
  - 41 jal: result = pc_e + 4, wreg = 31.
  - Branches 32–35, j 40, jr 42: result 0, wreg 0.
- wreg_e:
  - rd_e for op 0.
  - rt_e for ops 1, 3–6, 16, 18, 20.
  - 31 for jal.
  - 0 otherwise.
  - Undefined opcodes act as NOP.
- Reset:
  - Clears the D/E register only; all outputs then equal the NOP values (wreg_e=0, result_e=0).
  - Memory contents are NOT cleared; a store in the reset cycle is suppressed.

Optional Feature:
- DM_DEBUG_TAP_EN: when defined, adds output ports dbg_w133, dbg_w144 and dbg_w225 (32 bits each).
  - They combinationally expose memory words 133, 144 and 225 (byte addresses 532, 576, 900) for board display.
  - When not defined, these ports and their logic do not exist.

Decomposition:
- Shared package execute_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_BEQ..OP_BLE, OP_J, OP_JAL, OP_JR), funct constants, and the link register index 31.
- One sub-module, dmem_bytelane: 256x32 array with 4-bit lane write enables, asynchronous read and synchronous write. ALU and forwarding stay in the top.

Test Plan:
- Reset: rstd=0 for 2 cycles with op_d=1 presented -> wreg_e=0, result_e=0.
- addi: os=5, imm=-7, rt=9 -> result_e=0xFFFFFFFE, wreg_e=9.
- sra: ot=0x80000000, shamt=4 -> result_e=0xF8000000.
- Forwarding: rs_e=9, wreg_w=9, w_data_w=55 -> os_e=55. Same with wreg_w=0 -> registered os.
- Stores and loads:
  - sw 0x315 at ea=532, then lw ea=532 -> 0x00000315.
  - sb 0x80 at ea=533, then lb -> 0xFFFFFF80; lw -> 0x00008015.
- jal with pc_d=0x40 -> result_e=0x44, wreg_e=31. bubble_d=1 the next cycle -> wreg_e=0.
